// File: rtl/au_frame_sched_if.sv
// Signal bundle between the audio frame scheduler, its PCM source, the frame BRAM
// and the Ethernet transmitter. The slave side is the scheduler.
interface au_frame_sched_if;
    logic        en;
    logic        pcm_valid;
    logic [15:0] pcm_data;
    logic        bram_wr_en;
    logic [9:0]  bram_wr_addr;
    logic [7:0]  bram_wr_data;
    logic        eth_start;
    logic        eth_bank;
    logic        eth_busy;
    logic [15:0] overrun_cnt;

    modport master (
        output en, pcm_valid, pcm_data, eth_busy,
        input  bram_wr_en, bram_wr_addr, bram_wr_data, eth_start, eth_bank, overrun_cnt
    );

    modport slave (
        input  en, pcm_valid, pcm_data, eth_busy,
        output bram_wr_en, bram_wr_addr, bram_wr_data, eth_start, eth_bank, overrun_cnt
    );
endinterface

// File: rtl/au_frame_sched.sv
// Packs 16-bit PCM samples into two ping-pong 512-byte BRAM banks, stamps each full
// bank with a big-endian sequence number and hands it to the Ethernet transmitter.
module au_frame_sched #(
    parameter int unsigned HDR_LEN = 16,
    parameter int unsigned SEQ_OFS = 14
) (
    input logic             clk,
    input logic             rst,
    au_frame_sched_if.slave bus
);
    localparam logic [8:0] PtrInit  = 9'(HDR_LEN);
    localparam logic [8:0] SeqHiOfs = 9'(SEQ_OFS);
    localparam logic [8:0] SeqLoOfs = 9'(SEQ_OFS + 1);

    typedef enum logic [2:0] {StIdle, StWrLo, StWrHi, StSeqHi, StSeqLo} wr_state_e;
    typedef enum logic [1:0] {TxIdle, TxWait, TxRun} tx_state_e;

    wr_state_e   wr_state_q;
    tx_state_e   tx_state_q;
    logic [8:0]  ptr_q;
    logic        fill_bank_q;
    logic [7:0]  sample_hi_q;
    logic [15:0] seq_q;
    logic [1:0]  bank_full_q;
    logic [1:0]  bank_full_d;
    logic        tx_next_q;
    logic        wr_en_q;
    logic [9:0]  wr_addr_q;
    logic [7:0]  wr_data_q;
    logic        eth_start_q;
    logic        eth_bank_q;
    logic [15:0] overrun_q;

    logic pcm_req;
    logic take_sample;
    logic set_full;
    logic clr_full;

    assign pcm_req     = bus.en & bus.pcm_valid;
    assign take_sample = pcm_req && (wr_state_q == StIdle) && !bank_full_q[fill_bank_q];
    assign set_full    = (wr_state_q == StSeqLo);
    assign clr_full    = (tx_state_q == TxRun) && !bus.eth_busy;

    // The writer and transmitter never touch the same bank in one cycle.
    always_comb begin
        bank_full_d = bank_full_q;
        if (clr_full) bank_full_d[eth_bank_q] = 1'b0;
        if (set_full) bank_full_d[fill_bank_q] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_full_q <= 2'b00;
            overrun_q   <= 16'h0000;
        end else begin
            bank_full_q <= bank_full_d;
            if (pcm_req && !take_sample && (overrun_q != 16'hFFFF)) begin
                overrun_q <= overrun_q + 16'h0001;
            end
        end
    end

    // Write FSM: the BRAM port registers are loaded on entry to the state that owns them.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_q  <= StIdle;
            ptr_q       <= PtrInit;
            fill_bank_q <= 1'b0;
            sample_hi_q <= 8'h00;
            seq_q       <= 16'h0000;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= 10'h000;
            wr_data_q   <= 8'h00;
        end else begin
            unique case (wr_state_q)
                StIdle: begin
                    wr_en_q <= 1'b0;
                    if (take_sample) begin
                        sample_hi_q <= bus.pcm_data[15:8];
                        wr_en_q     <= 1'b1;
                        wr_addr_q   <= {fill_bank_q, ptr_q};
                        wr_data_q   <= bus.pcm_data[7:0];
                        wr_state_q  <= StWrLo;
                    end
                end
                StWrLo: begin
                    wr_en_q    <= 1'b1;
                    wr_addr_q  <= {fill_bank_q, ptr_q + 9'd1};
                    wr_data_q  <= sample_hi_q;
                    ptr_q      <= ptr_q + 9'd2;
                    wr_state_q <= StWrHi;
                end
                StWrHi: begin
                    // Pointer wrapped to zero: payload area of this bank is complete.
                    if (ptr_q == 9'd0) begin
                        wr_en_q    <= 1'b1;
                        wr_addr_q  <= {fill_bank_q, SeqHiOfs};
                        wr_data_q  <= seq_q[15:8];
                        wr_state_q <= StSeqHi;
                    end else begin
                        wr_en_q    <= 1'b0;
                        wr_state_q <= StIdle;
                    end
                end
                StSeqHi: begin
                    wr_en_q    <= 1'b1;
                    wr_addr_q  <= {fill_bank_q, SeqLoOfs};
                    wr_data_q  <= seq_q[7:0];
                    wr_state_q <= StSeqLo;
                end
                StSeqLo: begin
                    wr_en_q     <= 1'b0;
                    seq_q       <= seq_q + 16'h0001;
                    fill_bank_q <= ~fill_bank_q;
                    ptr_q       <= PtrInit;
                    wr_state_q  <= StIdle;
                end
                default: begin
                    wr_en_q    <= 1'b0;
                    wr_state_q <= StIdle;
                end
            endcase
        end
    end

    // Transmit FSM: banks are sent strictly in fill order, one at a time.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q  <= TxIdle;
            tx_next_q   <= 1'b0;
            eth_start_q <= 1'b0;
            eth_bank_q  <= 1'b0;
        end else begin
            eth_start_q <= 1'b0;
            unique case (tx_state_q)
                TxIdle: begin
                    if (bank_full_q[tx_next_q] && !bus.eth_busy) begin
                        eth_start_q <= 1'b1;
                        eth_bank_q  <= tx_next_q;
                        tx_state_q  <= TxWait;
                    end
                end
                TxWait: begin
                    if (bus.eth_busy) tx_state_q <= TxRun;
                end
                TxRun: begin
                    if (!bus.eth_busy) begin
                        tx_next_q  <= ~tx_next_q;
                        tx_state_q <= TxIdle;
                    end
                end
                default: tx_state_q <= TxIdle;
            endcase
        end
    end

    assign bus.bram_wr_en   = wr_en_q;
    assign bus.bram_wr_addr = wr_addr_q;
    assign bus.bram_wr_data = wr_data_q;
    assign bus.eth_start    = eth_start_q;
    assign bus.eth_bank     = eth_bank_q;
    assign bus.overrun_cnt  = overrun_q;
endmodule

// File: doc/au_frame_sched.md
AU_FRAME_SCHED -- requirements
Module: au_frame_sched

Interface
REQ-001 SHALL have parameter HDR_LEN, default 16, meaning header bytes reserved at the start of each bank; payload starts at bank base + HDR_LEN.
REQ-002 SHALL have parameter SEQ_OFS, default 14, meaning the bank offset of the 2-byte big-endian frame sequence number (SEQ_OFS+1 < HDR_LEN).
REQ-003 clk  in  1  sole clock; all logic on posedge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 en  in  1  capture enable.
REQ-006 pcm_valid  in  1  single-cycle strobe, pcm_data valid.
REQ-007 pcm_data  in  16  signed PCM sample.
REQ-008 bram_wr_en  out  1  BRAM byte write strobe.
REQ-009 bram_wr_addr  out  10  BRAM byte address; bit 9 = bank.
REQ-010 bram_wr_data  out  8  BRAM write byte.
REQ-011 eth_start  out  1  one-cycle frame transmit request.
REQ-012 eth_bank  out  1  bank the transmitter reads; drives transmitter address bit 9.
REQ-013 eth_busy  in  1  transmitter busy.
REQ-014 overrun_cnt  out  16  dropped-sample count, saturating at 0xFFFF.

Function
REQ-015 BRAM SHALL be two 512-byte banks (base 0, base 512); payload = 512-HDR_LEN bytes = 248 samples per frame at defaults.
REQ-016 Write FSM states SHALL be IDLE, WR_LO, WR_HI, SEQ_HI, SEQ_LO; fill pointer ptr (9 bits) and fill_bank are registered.
REQ-017 IDLE: pcm_valid=1, en=1, bank_full[fill_bank]=0 -> latch pcm_data, go WR_LO; pcm_valid=1, en=1, bank full -> sample dropped, overrun_cnt+1, stay IDLE; en=0 -> pcm_valid ignored, not counted.
REQ-018 WR_LO: one cycle bram_wr_en=1, addr={fill_bank,ptr}, data=sample[7:0]; WR_HI: addr={fill_bank,ptr+1}, data=sample[15:8], ptr+=2.
REQ-019 Latency: strobe in cycle N -> low byte written cycle N+1, high byte cycle N+2.
REQ-020 After WR_HI, if new ptr = 0 (wrapped, bank payload complete) -> SEQ_HI, else IDLE.
REQ-021 SEQ_HI writes seq[15:8] at {fill_bank,SEQ_OFS}; SEQ_LO writes seq[7:0] at {fill_bank,SEQ_OFS+1}, then sets bank_full[fill_bank], seq+1 (wraps 0xFFFF->0), toggles fill_bank, ptr=HDR_LEN, returns IDLE.
REQ-022 pcm_valid arriving outside IDLE SHALL be dropped and counted when en=1.
REQ-023 bram_wr_en SHALL be 0 in IDLE; bram_wr_addr/data hold last value when not writing.
REQ-024 TX FSM states SHALL be TX_IDLE, TX_WAIT, TX_RUN; pointer tx_next (1 bit) gives oldest full bank.
REQ-025 TX_IDLE: bank_full[tx_next]=1 and eth_busy=0 -> eth_start=1 for exactly one cycle, eth_bank=tx_next, go TX_WAIT.
REQ-026 TX_WAIT: eth_busy=1 -> TX_RUN. TX_RUN: eth_busy=0 -> clear bank_full[eth_bank], toggle tx_next, TX_IDLE.
REQ-027 eth_bank SHALL be stable from eth_start until the bank is freed.
REQ-028 Bank free SHALL take effect the cycle after the eth_busy fall; pcm_valid in the free cycle against that full bank is dropped and counted.
REQ-029 Set (REQ-021) and clear (REQ-026) of the same bank in one cycle cannot occur; both banks full is legal, writer drops until free.
REQ-030 seq SHALL be the count of frames completed since reset; first frame carries 0x0000.

Reset
REQ-031 On rst: write FSM IDLE, TX FSM TX_IDLE, ptr=HDR_LEN, fill_bank=0, tx_next=0, bank_full=00, seq=0, overrun_cnt=0, bram_wr_en=0, bram_wr_addr=0, bram_wr_data=0, eth_start=0, eth_bank=0.
REQ-032 rst mid-frame or mid-transmit SHALL abandon partial frame; no eth_start until a new full frame.

Verification
REQ-033 Single sample 0x1234 after reset -> cycle N+1 write 0x34 @16, N+2 write 0x12 @17.
REQ-034 248 samples, eth_busy idle -> bytes @14/15 = 0x00/0x00, eth_start pulse with eth_bank=0, next sample written @528.
REQ-035 Second frame -> seq bytes @526/527 = 0x00/0x01; eth_start with eth_bank=1 only after bank 0 busy cycle completes.
REQ-036 eth_busy held high, 3x248 samples + 5 -> two frames full, 253 samples dropped, overrun_cnt=253.
REQ-037 rst asserted after 100 samples -> all outputs reset values, next sample written @16, no eth_start.
